progmem_loader: RTL and testbench
=================================

PROGMEM_LOADER -- requirements
Module: progmem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of the program memory port.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle load request, sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  cancel an in-progress load.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, captured on start.
REQ-007 SHALL have port word_count  input  ADDR_W+1  number of 32-bit words to load, captured on start.
REQ-008 SHALL have port s_data  input  8  byte stream data.
REQ-009 SHALL have port s_valid  input  1  byte stream valid.
REQ-010 SHALL have port s_ready  output  1  byte stream ready.
REQ-011 SHALL have port m_address  output  ADDR_W  memory word address.
REQ-012 SHALL have port m_write  output  1  memory write request.
REQ-013 SHALL have port m_writedata  output  32  memory write data.
REQ-014 SHALL have port m_byteenable  output  4  memory byte enables.
REQ-015 SHALL have port m_read  output  1  memory read request.
REQ-016 SHALL have port m_readdata  input  32  memory read data.
REQ-017 SHALL have port m_waitrequest  input  1  memory stall.
REQ-018 SHALL have port busy  output  1  high in any state except IDLE.
REQ-019 SHALL have port done  output  1  sticky load-complete flag.
REQ-020 SHALL have port error  output  1  sticky verify-mismatch flag.

Function
REQ-021 SHALL implement FSM states IDLE, COLLECT, WRITE, RDBACK, FINISH.
REQ-022 IDLE: start=1 with word_count=0 SHALL go to FINISH with no bus activity; start=1 with word_count>0 SHALL capture base_addr and word_count, clear done and error, and go to COLLECT.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 COLLECT: s_ready=1; each s_valid&&s_ready byte SHALL fill one byte lane, little-endian (first byte in bits 7:0); the fourth byte SHALL go to WRITE.
REQ-025 s_ready SHALL be 0 in every state except COLLECT.
REQ-026 WRITE: m_write=1, m_byteenable=4'hF; m_address and m_writedata SHALL hold stable while m_waitrequest=1.
REQ-027 A write SHALL complete in the cycle with m_write=1 and m_waitrequest=0; the next state is RDBACK when verify is compiled in, otherwise COLLECT or FINISH.
REQ-028 RDBACK: m_read=1 at the same address; m_readdata SHALL be compared in the cycle with m_read=1 and m_waitrequest=0.
REQ-029 A readback mismatch SHALL set error and go to FINISH; a match SHALL advance as in REQ-030.
REQ-030 After each completed word, the address SHALL increment modulo 2^ADDR_W (wrap to 0) and the remaining count SHALL decrement; at remaining count 0 the FSM SHALL go to FINISH, else to COLLECT.
REQ-031 FINISH: set done and go to IDLE the next cycle; done and error SHALL hold until the next accepted start.
REQ-032 abort in COLLECT or FINISH SHALL go to IDLE in the next cycle with done=0 and partial bytes discarded.
REQ-033 abort in WRITE or RDBACK SHALL be latched and take effect only after the current transaction completes; a bus request SHALL never drop while m_waitrequest=1.
REQ-034 m_write and m_read SHALL never be asserted together.
REQ-035 abort and start in the same IDLE cycle: start SHALL win and abort SHALL be ignored.

Reset
REQ-036 rst_n low SHALL asynchronously force IDLE, s_ready=0, m_write=0, m_read=0, m_address=0, m_writedata=0, m_byteenable=0, busy=0, done=0, error=0, byte lane index=0, and clear any latched abort.
REQ-037 Reset mid-transaction SHALL drop requests immediately; no recovery is provided.

Configuration
REQ-038 With PROGMEM_LOADER_VERIFY_EN defined, the RDBACK state and error logic SHALL be present.
REQ-039 Without PROGMEM_LOADER_VERIFY_EN, RDBACK SHALL be absent, m_read SHALL be tied to 0, and error SHALL be tied to 0.

Verification
REQ-040 base=0x0010, count=2, bytes 01 02 03 04 05 06 07 08, waitrequest=0 -> writes 0x04030201@0x0010 then 0x08070605@0x0011, then done=1 and busy=0.
REQ-041 Each write held by waitrequest for 2 cycles -> m_address and m_writedata stable for 3 cycles; exactly one write per word.
REQ-042 base=0x3FFF, count=2 -> writes to 0x3FFF then 0x0000.
REQ-043 count=0 -> done=1 two cycles after start; no m_write or m_read activity.
REQ-044 abort during a stalled WRITE -> m_write stays high until waitrequest=0, then IDLE with done=0 and busy=0.
REQ-045 VERIFY_EN defined, memory model corrupts bit 0 of word 1 of 3 -> error=1, done=1, and word 2 is never written.

Source files
------------

// File: rtl/progmem_loader.sv
// Streams bytes into 32-bit little-endian words and writes them to program memory.
// Define PROGMEM_LOADER_VERIFY_EN to add a read-back compare after every write.
module progmem_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_read,
  input  logic [31:0]       m_readdata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef PROGMEM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_RDBACK, S_FINISH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_FINISH} state_t;
`endif

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic [31:0]       r_wdata;
  logic [1:0]        r_lane;
  logic              r_abort;
  logic              r_done;
  logic              w_start, w_byte, w_advance, w_set_done, w_abort, w_last;
`ifdef PROGMEM_LOADER_VERIFY_EN
  logic              r_error;
  logic              w_set_err;
`else
  logic              w_unused;
  assign w_unused = ^m_readdata;
`endif

  // An abort raised during a bus transaction counts from the cycle it was seen.
  assign w_abort = abort | r_abort;
  assign w_last  = (r_remain == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_byte     = 1'b0;
    w_advance  = 1'b0;
    w_set_done = 1'b0;
`ifdef PROGMEM_LOADER_VERIFY_EN
    w_set_err  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start = 1'b1;
          w_next  = (word_count == '0) ? S_FINISH : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (abort) w_next = S_IDLE;
        else if (s_valid) begin
          w_byte = 1'b1;
          if (r_lane == 2'd3) w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!m_waitrequest) begin
          if (w_abort) w_next = S_IDLE;
          else begin
`ifdef PROGMEM_LOADER_VERIFY_EN
            w_next = S_RDBACK;
`else
            w_advance = 1'b1;
            w_next    = w_last ? S_FINISH : S_COLLECT;
`endif
          end
        end
      end
`ifdef PROGMEM_LOADER_VERIFY_EN
      S_RDBACK: begin
        if (!m_waitrequest) begin
          if (m_readdata != r_wdata) begin
            w_set_err = 1'b1;
            w_next    = w_abort ? S_IDLE : S_FINISH;
          end else begin
            w_advance = 1'b1;
            w_next    = w_abort ? S_IDLE : (w_last ? S_FINISH : S_COLLECT);
          end
        end
      end
`endif
      S_FINISH: begin
        w_next     = S_IDLE;
        w_set_done = ~abort;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_wdata  <= '0;
      r_lane   <= '0;
      r_abort  <= 1'b0;
      r_done   <= 1'b0;
`ifdef PROGMEM_LOADER_VERIFY_EN
      r_error  <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_addr   <= base_addr;
        r_remain <= word_count;
        r_done   <= 1'b0;
`ifdef PROGMEM_LOADER_VERIFY_EN
        r_error  <= 1'b0;
`endif
      end
      if (w_byte) begin
        r_wdata[{r_lane, 3'b000} +: 8] <= s_data;
        r_lane <= r_lane + 2'd1;
      end
      if (w_advance) begin
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
      if (w_set_done) r_done <= 1'b1;
`ifdef PROGMEM_LOADER_VERIFY_EN
      if (w_set_err) r_error <= 1'b1;
`endif
      // Returning to IDLE drops any partial word and any pending abort.
      if (w_next == S_IDLE) begin
        r_abort <= 1'b0;
        r_lane  <= '0;
      end else if (abort && (m_write || m_read)) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign s_ready      = (r_state == S_COLLECT);
  assign m_write      = (r_state == S_WRITE);
  assign m_byteenable = m_write ? 4'hF : 4'h0;
  assign m_address    = r_addr;
  assign m_writedata  = r_wdata;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
`ifdef PROGMEM_LOADER_VERIFY_EN
  assign m_read       = (r_state == S_RDBACK);
  assign error        = r_error;
`else
  assign m_read       = 1'b0;
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_progmem_loader.sv
// Randomized scoreboard bench for progmem_loader: a memory model with configurable
// stalls, an expected-write queue fed by the stimulus, and a monitor that drains it.
module tb_progmem_loader;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] m_address;
  logic          m_write;
  logic [31:0]   m_writedata;
  logic [3:0]    m_byteenable;
  logic          m_read;
  logic [31:0]   m_readdata;
  logic          m_waitrequest;
  logic          busy, done, error;

  progmem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_read(m_read), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] byte_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- memory model ----------------
  int          cfg_stall  = 0;   // <0 selects random stalls of 0..2 cycles
  int          stall_len  = 0;
  int          req_age    = 0;
  int          wr_idx     = 0;
  int          corrupt_at = -1;
  logic [31:0] last_wr    = '0;
  logic        w_req;

  assign w_req         = m_write | m_read;
  assign m_waitrequest = w_req && (req_age < stall_len);
  assign m_readdata    = last_wr ^ {31'b0, (corrupt_at >= 0) && (wr_idx - 1 == corrupt_at)};

  always @(posedge clk) begin
    if (!w_req || !m_waitrequest)
      stall_len <= (cfg_stall >= 0) ? cfg_stall : int'($urandom_range(0, 2));
    if (w_req && m_waitrequest) req_age <= req_age + 1;
    else                        req_age <= 0;
    if (m_write && !m_waitrequest) begin
      last_wr <= m_writedata;
      wr_idx  <= wr_idx + 1;
    end
  end

  // ---------------- monitor ----------------
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;
  int            hold = 0;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      hold       = 0;
    end else begin
      if (m_write && m_read) chk("write_read_overlap", 1, 0);
`ifndef PROGMEM_LOADER_VERIFY_EN
      if (m_read) chk("read_tied_low", m_read, 0);
      if (error)  chk("error_tied_low", error, 0);
`endif
      if (prev_stall) begin
        chk("stall_write_held", m_write, 1);
        chk("stall_addr_stable", m_address, prev_addr);
        chk("stall_data_stable", m_writedata, prev_data);
      end
      if (m_write) hold++;
      if (m_write && !m_waitrequest) begin
        if (exp_q.size() == 0) chk("unexpected_write", m_address, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", m_address, mon_e.addr);
          chk("write_data", m_writedata, mon_e.data);
          chk("write_be", m_byteenable, 4'hF);
        end
        if (cfg_stall >= 0) chk("write_hold_cycles", hold, cfg_stall + 1);
        hold = 0;
      end
      prev_stall = m_write && m_waitrequest;
      prev_addr  = m_address;
      prev_data  = m_writedata;
    end
  end

  // ---------------- reference model & stimulus ----------------
  function automatic void model_push(input int b, input int nw);
    for (int i = 0; i < nw; i++) begin
      exp_t e;
      e.addr = AW'((b + i) % (1 << AW));
      e.data = {byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]};
      exp_q.push_back(e);
    end
  endfunction

  function automatic void fill_rand(input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
  endfunction

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_data = b; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 200) begin chk("s_ready_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int t = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      t++;
      if (t > 2000) begin chk("idle_timeout", busy, 0); break; end
    end
  endtask

  task automatic load(input int b, input int cnt, input int stall, input int nexp);
    cfg_stall = stall;
    model_push(b, nexp);
    do_start(AW'(b), (AW+1)'(cnt));
    for (int i = 0; i < 4*nexp; i++) send_byte(byte_q[i]);
    wait_idle();
  endtask

  task automatic post_check(input string nm, input logic exp_done, input logic exp_err);
    chk({nm, "_done"}, done, exp_done);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_error"}, error, exp_err);
    chk({nm, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
    s_data = '0; s_valid = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_m_writedata", m_writedata, 0);
    chk("rst_m_byteenable", m_byteenable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed little-endian packing
    byte_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    model_push(0, 0);
    exp_q.push_back('{addr: 14'h0010, data: 32'h04030201});
    exp_q.push_back('{addr: 14'h0011, data: 32'h08070605});
    cfg_stall = 0;
    do_start(14'h0010, 15'd2);
    for (int i = 0; i < 8; i++) send_byte(byte_q[i]);
    wait_idle();
    post_check("basic", 1, 0);

    // every write stalled two cycles
    fill_rand(12);
    load(14'h0123, 3, 2, 3);
    post_check("stall2", 1, 0);

    // address wrap
    fill_rand(8);
    load(14'h3FFF, 2, -1, 2);
    post_check("wrap", 1, 0);

    // zero-length load: done two cycles after start, no bus traffic
    @(posedge clk); #1;
    do_start(14'h0200, 15'd0);
    @(negedge clk);
    chk("zero_done_early", done, 0);
    chk("zero_busy_early", busy, 1);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(posedge clk); #1;

    // abort during a stalled write: the write still completes, then IDLE
    begin
      int t = 0;
      fill_rand(12);
      cfg_stall = 3;
      model_push(14'h0400, 1);
      do_start(14'h0400, 15'd3);
      for (int i = 0; i < 4; i++) send_byte(byte_q[i]);
      do begin @(negedge clk); t++; end while (!(m_write && m_waitrequest) && t < 100);
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      wait_idle();
      post_check("abort_write", 0, 0);
      chk("abort_write_s_ready", s_ready, 0);
    end

    // abort while collecting discards the partial word
    fill_rand(4);
    cfg_stall = -1;
    do_start(14'h0500, 15'd1);
    send_byte(byte_q[0]);
    send_byte(byte_q[1]);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    wait_idle();
    post_check("abort_collect", 0, 0);
    fill_rand(4);
    load(14'h0501, 1, -1, 1);
    post_check("after_abort", 1, 0);

    // start is ignored while a load is in progress
    fill_rand(8);
    cfg_stall = 1;
    model_push(14'h0700, 2);
    do_start(14'h0700, 15'd2);
    send_byte(byte_q[0]);
    send_byte(byte_q[1]);
    do_start(14'h2222, 15'd1);
    for (int i = 2; i < 8; i++) send_byte(byte_q[i]);
    wait_idle();
    post_check("start_ignored", 1, 0);

    // randomized loads
    for (int n = 0; n < 8; n++) begin
      int b, c;
      b = (n % 3 == 0) ? int'($urandom_range(16380, 16383)) : int'($urandom_range(0, 16383));
      c = int'($urandom_range(1, 5));
      fill_rand(4*c);
      load(b, c, -1, c);
      post_check("random", 1, 0);
    end

`ifdef PROGMEM_LOADER_VERIFY_EN
    // corrupted read-back of word 1 of 3 stops the load
    fill_rand(12);
    corrupt_at = wr_idx + 1;
    load(14'h0900, 3, -1, 2);
    post_check("verify_err", 1, 1);
    corrupt_at = -1;
    fill_rand(4);
    load(14'h0A00, 1, -1, 1);
    post_check("verify_clear", 1, 0);
`endif

    // reset mid-write drops the request immediately
    fill_rand(4);
    cfg_stall = 5;
    do_start(14'h0C00, 15'd1);
    for (int i = 0; i < 4; i++) send_byte(byte_q[i]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_write", m_write, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_m_address", m_address, 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
